// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam int         DEF_DIGITS = 4;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one bit per clock.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with the blank code.
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf
);

  // One spare digit above the presented ones catches overflow without losing bits.
  localparam int ND = DIGITS + 1;
  localparam int AW = 4 * ND;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [AW-1:0]        acc_q, acc_adj, acc_d;
  logic [CW-1:0]        cnt_q;
  logic [4*DIGITS-1:0]  bcd_d;
  logic                 ovf_d;

  for (genvar g = 0; g < ND; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[4*g +: 4]),
      .d_o (acc_adj[4*g +: 4])
    );
  end

  assign acc_d    = (acc_adj << 1) | AW'(bin_q[WIDTH-1]);
  assign bin_d    = bin_q << 1;
  assign in_ready = (state_q == IDLE);

  always_comb begin
    ovf_d = |acc_q[AW-1 -: 4];
    bcd_d = acc_q[4*DIGITS-1:0];
`ifdef LEADING_ZERO_BLANK_EN
    begin : blank
      logic lead;
      // Walk down from the top digit; digit 0 is never blanked.
      lead = !ovf_d;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (acc_q[4*i +: 4] != 4'd0) lead = 1'b0;
        if (lead) bcd_d[4*i +: 4] = BCD_BLANK;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_bcd   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q   <= in_bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: begin
          out_bcd   <= bcd_d;
          out_ovf   <= ovf_d;
          out_valid <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq at default parameters (WIDTH=14, DIGITS=4).
module tb_bin_to_bcd_seq;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [13:0] in_bin = '0;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_bcd;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_bcd   (out_bcd),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion: checks latency, result, ready-with-valid, single-cycle pulse and hold.
  task automatic convert(input string tag, input logic [13:0] v,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin tick(); n++; end
    in_valid = 1'b1;
    in_bin   = v;
    tick();
    in_valid = 1'b0;
    in_bin   = ~v;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk({tag, ".latency"}, n, 15);
    chk({tag, ".bcd"}, out_bcd, exp_bcd);
    chk({tag, ".ovf"}, out_ovf, exp_ovf);
    chk({tag, ".ready_with_valid"}, in_ready, 1'b1);
    tick();
    chk({tag, ".pulse_one_cycle"}, out_valid, 1'b0);
    chk({tag, ".hold"}, out_bcd, exp_bcd);
  endtask

  initial begin
    int n;
    int seen;

    tick();
    tick();
    chk("reset.in_ready", in_ready, 1'b1);
    chk("reset.out_valid", out_valid, 1'b0);
    chk("reset.out_bcd", out_bcd, 16'h0000);
    chk("reset.out_ovf", out_ovf, 1'b0);
    reset = 1'b0;
    tick();

    convert("zero",  14'd0,     BLK ? 16'hFFF0 : 16'h0000, 1'b0);
    convert("seven", 14'd7,     BLK ? 16'hFFF7 : 16'h0007, 1'b0);
    convert("k1000", 14'd1000,  16'h1000, 1'b0);
    convert("n9999", 14'd9999,  16'h9999, 1'b0);
    convert("max",   14'd16383, 16'h6383, 1'b1);
    convert("ovf12345", 14'd12345, 16'h2345, 1'b1);
    convert("ovf10000", 14'd10000, 16'h0000, 1'b1);

    // Back-to-back with in_valid held high; in_bin scrambled while shifting.
    in_valid = 1'b1;
    in_bin   = 14'd42;
    tick();
    in_bin = 14'd5555;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk("b2b.first.latency", n, 15);
    chk("b2b.first.bcd", out_bcd, BLK ? 16'hFF42 : 16'h0042);
    chk("b2b.first.ready", in_ready, 1'b1);
    in_bin = 14'd1234;
    tick();
    in_bin = 14'd777;
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    in_valid = 1'b0;
    chk("b2b.gap_cycles", n - 1, 15);
    chk("b2b.second.bcd", out_bcd, 16'h1234);
    chk("b2b.second.ovf", out_ovf, 1'b0);
    tick();
    chk("b2b.no_third", out_valid, 1'b0);

    // Reset 7 cycles into a conversion of 500.
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin tick(); n++; end
    in_valid = 1'b1;
    in_bin   = 14'd500;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    in_valid = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rst_mid.out_valid", out_valid, 1'b0);
    chk("rst_mid.out_bcd", out_bcd, 16'h0000);
    chk("rst_mid.out_ovf", out_ovf, 1'b0);
    chk("rst_mid.in_ready", in_ready, 1'b1);
    tick();
    chk("rst_mid.ready_after_release", in_ready, 1'b1);
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    chk("rst_mid.no_pulse", seen, 0);

    convert("after_rst500", 14'd500, BLK ? 16'hF500 : 16'h0500, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
